// File: rtl/mips_alu_pkg.sv
// Shared ALU control codes, MIPS opcode/funct constants and the issue packet type.
// Used by the issue stage and the ALU.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADDU = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_SUBU = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  dest;
        logic        illegal;
    } issue_pkt_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'b0, v};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Maps a MIPS instruction plus register operands onto ALU control, operands and destination.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage decides when the result is captured.
module alu_issue_decode
    import mips_alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  ctrl,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  dest,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt;
    logic        unused_rs_field;

    assign opcode = instr[31:26];
    assign rt_f   = instr[20:16];
    assign rd_f   = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    // The rs index is resolved by the register file; only its data arrives here.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        ctrl    = ALU_AND;
        in1     = '0;
        in2     = '0;
        dest    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                in1  = rs_data;
                in2  = rt_data;
                dest = rd_f;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl = ALU_ADDU;
                    FN_SUB, FN_SUBU: ctrl = ALU_SUBU;
                    FN_AND:          ctrl = ALU_AND;
                    FN_OR:           ctrl = ALU_OR;
                    FN_XOR:          ctrl = ALU_XOR;
                    FN_NOR:          ctrl = ALU_NOR;
                    FN_SLT:          ctrl = ALU_SLT;
                    FN_SLTU:         ctrl = ALU_SLTU;
                    FN_SLL: begin ctrl = ALU_SLL; in1 = {27'b0, shamt}; end
                    FN_SRL: begin ctrl = ALU_SRL; in1 = {27'b0, shamt}; end
                    FN_SRA: begin ctrl = ALU_SRA; in1 = {27'b0, shamt}; end
                    FN_SLLV: begin ctrl = ALU_SLL; in1 = {27'b0, rs_data[4:0]}; end
                    FN_SRLV: begin ctrl = ALU_SRL; in1 = {27'b0, rs_data[4:0]}; end
                    FN_SRAV: begin ctrl = ALU_SRA; in1 = {27'b0, rs_data[4:0]}; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                ctrl = ALU_ADDU; in1 = rs_data; in2 = sext16(imm); dest = rt_f;
            end
            OP_SLTI: begin
                ctrl = ALU_SLT; in1 = rs_data; in2 = sext16(imm); dest = rt_f;
            end
            OP_SLTIU: begin
                ctrl = ALU_SLTU; in1 = rs_data; in2 = sext16(imm); dest = rt_f;
            end
            OP_ANDI: begin
                ctrl = ALU_AND; in1 = rs_data; in2 = zext16(imm); dest = rt_f;
            end
            OP_ORI: begin
                ctrl = ALU_OR; in1 = rs_data; in2 = zext16(imm); dest = rt_f;
            end
            OP_XORI: begin
                ctrl = ALU_XOR; in1 = rs_data; in2 = zext16(imm); dest = rt_f;
            end
            // lui is built as 0 | (imm << 16) so the ALU needs no dedicated op.
            OP_LUI: begin
                ctrl = ALU_OR; in1 = '0; in2 = {imm, 16'b0}; dest = rt_f;
            end
            // Store only needs the address; rt is data, not a destination.
            OP_SW: begin
                ctrl = ALU_ADDU; in1 = rs_data; in2 = sext16(imm); dest = '0;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = ALU_AND;
            in1  = '0;
            in2  = '0;
            dest = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry registered issue stage between decode and the ALU.
// Latency: 1 cycle from input transfer to out_valid; full throughput when out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a stalled packet holds all outputs stable.
module alu_issue_stage
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  dest_addr,
    output logic        illegal
);

    issue_pkt_t dec_pkt;
    issue_pkt_t pkt_q;
    logic       valid_q;
    logic       load;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    logic [4:0]  dec_dest;
    logic        dec_illegal;

    alu_issue_decode u_decode (
        .instr   (instr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .ctrl    (dec_ctrl),
        .in1     (dec_in1),
        .in2     (dec_in2),
        .dest    (dec_dest),
        .illegal (dec_illegal)
    );

    assign dec_pkt = '{ctrl: dec_ctrl, in1: dec_in1, in2: dec_in2,
                       dest: dec_dest, illegal: dec_illegal};

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Flush beats load; payload only moves on a real input transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pkt_q   <= dec_pkt;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign alu_ctrl  = pkt_q.ctrl;
    assign alu_in1   = pkt_q.in1;
    assign alu_in2   = pkt_q.in2;
    assign dest_addr = pkt_q.dest;
    assign illegal   = pkt_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized check of alu_issue_stage against a table-driven reference model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  dest_addr;
    logic        illegal;

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .dest_addr (dest_addr),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  dest;
        logic        ill;
    } ref_t;

    // Lookup tables: code -1 = unmapped. kinds: R 1=reg,2=shamt,3=var shift; I 1=sext,2=zext,3=lui,4=store.
    int fn_code[64];
    int fn_kind[64];
    int op_code[64];
    int op_kind[64];

    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_valid;
    bit   m_pz;
    ref_t m_pkt;
    ref_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ref_t ref_pkt(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        ref_t p;
        int op, fn;
        logic [15:0] imm;
        op  = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        imm = ins[15:0];
        p   = '0;
        if (op == 0) begin
            if (fn_code[fn] < 0) p.ill = 1'b1;
            else begin
                p.ctrl = 4'(fn_code[fn]);
                p.in2  = rt;
                p.dest = ins[15:11];
                if (fn_kind[fn] == 2)      p.in1 = 32'(ins[10:6]);
                else if (fn_kind[fn] == 3) p.in1 = rs % 32;
                else                       p.in1 = rs;
            end
        end else if (op_code[op] < 0) begin
            p.ill = 1'b1;
        end else begin
            p.ctrl = 4'(op_code[op]);
            p.in1  = rs;
            p.dest = ins[20:16];
            case (op_kind[op])
                1: p.in2 = 32'($signed(imm));
                2: p.in2 = 32'(imm);
                3: begin p.in1 = 0; p.in2 = 32'(imm) << 16; end
                default: begin p.in2 = 32'($signed(imm)); p.dest = 0; end
            endcase
        end
        return p;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [5:0] fns [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07};
        logic [5:0] ops [10] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 4)
            0: begin
                r[31:26] = 6'h00;
                r[5:0] = ($urandom % 8 == 0) ? 6'($urandom) : fns[$urandom % 16];
            end
            1, 2: r[31:26] = ops[$urandom % 10];
            default: ;
        endcase
        return r;
    endfunction

    // One clock: check ready and scoreboard before the edge, then update the model and check outputs.
    task automatic tick();
        ref_t d, e;
        bit acc, drain;
        @(negedge clk);
        chk("in_ready", in_ready, (!m_valid || out_ready));
        acc   = in_valid && (!m_valid || out_ready);
        drain = m_valid && out_ready;
        if (drain && rst_n && !flush) begin
            chk("sb_size", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_ctrl", alu_ctrl, e.ctrl);
                chk("sb_in1", alu_in1, e.in1);
                chk("sb_in2", alu_in2, e.in2);
                chk("sb_dest", dest_addr, e.dest);
            end
        end
        d = ref_pkt(instr, rs_data, rt_data);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_pkt = '0; m_pz = 1; sb.delete();
        end else if (flush) begin
            m_valid = 0; sb.delete();
        end else if (acc) begin
            m_valid = 1; m_pkt = d; m_pz = 0; sb.push_back(d);
        end else if (drain) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid || m_pz) begin
            chk("alu_ctrl", alu_ctrl, m_pkt.ctrl);
            chk("alu_in1", alu_in1, m_pkt.in1);
            chk("alu_in2", alu_in2, m_pkt.in2);
            chk("dest_addr", dest_addr, m_pkt.dest);
            chk("illegal", illegal, m_pkt.ill);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            fn_code[i] = -1; fn_kind[i] = 1; op_code[i] = -1; op_kind[i] = 1;
        end
        fn_code['h20] = 2;  fn_code['h21] = 2;  fn_code['h22] = 6;  fn_code['h23] = 6;
        fn_code['h24] = 0;  fn_code['h25] = 1;  fn_code['h26] = 9;  fn_code['h27] = 12;
        fn_code['h2A] = 7;  fn_code['h2B] = 14;
        fn_code['h00] = 10; fn_code['h04] = 10; fn_code['h02] = 3;  fn_code['h06] = 3;
        fn_code['h03] = 11; fn_code['h07] = 11;
        fn_kind['h00] = 2;  fn_kind['h02] = 2;  fn_kind['h03] = 2;
        fn_kind['h04] = 3;  fn_kind['h06] = 3;  fn_kind['h07] = 3;
        op_code['h08] = 2;  op_code['h09] = 2;  op_code['h0A] = 7;  op_code['h0B] = 14;
        op_code['h0C] = 0;  op_code['h0D] = 1;  op_code['h0E] = 9;  op_code['h0F] = 1;
        op_code['h23] = 2;  op_code['h2B] = 2;
        op_kind['h0C] = 2;  op_kind['h0D] = 2;  op_kind['h0E] = 2;
        op_kind['h0F] = 3;  op_kind['h2B] = 4;

        m_valid = 0; m_pz = 1; m_pkt = '0;
        rst_n = 0; in_valid = 0; instr = '0; rs_data = '0; rt_data = '0;
        flush = 0; out_ready = 0;

        // Reset state
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_in1", alu_in1, 0);
        chk("rst_in2", alu_in2, 0);
        chk("rst_dest", dest_addr, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // addu $8,$9,$10
        in_valid = 1; out_ready = 1; instr = 32'h012A4021; rs_data = 5; rt_data = 7;
        tick();
        chk("addu_valid", out_valid, 1);
        chk("addu_ctrl", alu_ctrl, 4'b0010);
        chk("addu_in1", alu_in1, 5);
        chk("addu_in2", alu_in2, 7);
        chk("addu_dest", dest_addr, 8);
        chk("addu_illegal", illegal, 0);

        // sra $8,$9,2
        instr = 32'h00094083; rs_data = 32'h123; rt_data = 32'h80000000;
        tick();
        chk("sra_ctrl", alu_ctrl, 4'b1011);
        chk("sra_in1", alu_in1, 2);
        chk("sra_in2", alu_in2, 32'h80000000);
        chk("sra_dest", dest_addr, 8);

        // lui then addi
        instr = 32'h3C081234; rs_data = 32'hDEADBEEF;
        tick();
        chk("lui_ctrl", alu_ctrl, 4'b0001);
        chk("lui_in1", alu_in1, 0);
        chk("lui_in2", alu_in2, 32'h12340000);
        instr = 32'h2128FFFF; rs_data = 1;
        tick();
        chk("addi_ctrl", alu_ctrl, 4'b0010);
        chk("addi_in1", alu_in1, 1);
        chk("addi_in2", alu_in2, 32'hFFFFFFFF);
        chk("addi_dest", dest_addr, 8);

        // Stall three cycles with a pending input, then stream back-to-back
        out_ready = 0; instr = 32'h350800FF; rs_data = 32'h55;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_in_ready", in_ready, 0);
            chk("stall_in2", alu_in2, 32'hFFFFFFFF);
            chk("stall_valid", out_valid, 1);
        end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            instr = 32'h012A4021; rs_data = 32'(100 + k); rt_data = 32'(k);
            tick();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_in1", alu_in1, 32'(100 + k));
        end

        // Flush with held packet and incoming instruction
        out_ready = 0; flush = 1; in_valid = 1; instr = 32'h012A4021;
        tick();
        chk("flush_valid", out_valid, 0);
        flush = 0; in_valid = 0;
        tick();
        chk("flush_idle", out_valid, 0);

        // Illegal opcode, then reset during a stall
        in_valid = 1; out_ready = 1; instr = 32'hFC000000; rs_data = 9; rt_data = 9;
        tick();
        chk("ill_flag", illegal, 1);
        chk("ill_ctrl", alu_ctrl, 0);
        chk("ill_dest", dest_addr, 0);
        chk("ill_in1", alu_in1, 0);
        out_ready = 0; instr = 32'h012A4021; rs_data = 3; rt_data = 4;
        tick(); tick();
        rst_n = 0;
        tick();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_ctrl", alu_ctrl, 0);
        chk("rst2_in1", alu_in1, 0);
        chk("rst2_in2", alu_in2, 0);
        chk("rst2_dest", dest_addr, 0);
        chk("rst2_illegal", illegal, 0);
        rst_n = 1; in_valid = 0;
        #1;
        chk("rst2_in_ready", in_ready, 1);
        tick();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            rst_n     = ($urandom % 97) != 0;
            instr     = gen_instr();
            rs_data   = ($urandom % 8 == 0) ? 32'h80000000 : $urandom;
            rt_data   = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
